// File: rtl/pid_avalon_master.sv
// Avalon-MM master sequencing one PID controller slave: optional gain load
// (addr 1/2/3), setpoint/process-value writes (addr 4/5), a settle wait and
// a result read (addr 0). Bus outputs are registered and derived from the
// next state so they line up with the state register.
module pid_avalon_master #(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic signed [31:0] sp_in,
  input  logic signed [31:0] pv_in,
  input  logic               gain_load,
  input  logic signed [31:0] kp_in,
  input  logic signed [31:0] kd_in,
  input  logic signed [31:0] ki_in,
  output logic               busy,
  output logic signed [31:0] result_out,
  output logic               result_valid,
  output logic               timeout_err,
  output logic [3:0]         avm_address,
  output logic               avm_write,
  output logic [31:0]        avm_writedata,
  output logic               avm_read,
  input  logic [31:0]        avm_readdata,
  input  logic               avm_waitrequest
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    WR_KP  = 4'd1,
    WR_KD  = 4'd2,
    WR_KI  = 4'd3,
    WR_SP  = 4'd4,
    WR_PV  = 4'd5,
    SETTLE = 4'd6,
    RD_RES = 4'd7,
    DONE   = 4'd8
  } state_t;

  state_t      state_r, next_state_s;
  logic [31:0] sp_r, pv_r, kp_r, kd_r, ki_r;
  logic [31:0] sp_nx_s, pv_nx_s, kp_nx_s, kd_nx_s, ki_nx_s;
  logic        chain_r, chain_nx_s;
  logic        pending_r, pending_nx_s;
  logic [7:0]  settle_cnt_r;
  logic [15:0] stall_cnt_r;
  logic [3:0]  addr_nx_s;
  logic        write_nx_s, read_nx_s;
  logic [31:0] wdata_nx_s;

  logic strobe_s, done_acc_s, stalled_s, timeout_s, settle_end_s;
  logic in_gain_s, in_ctrl_s, accept_start_s, accept_gain_s, idle_accept_s;

  assign strobe_s       = avm_write | avm_read;
  assign done_acc_s     = strobe_s & ~avm_waitrequest;
  assign stalled_s      = strobe_s & avm_waitrequest;
  // abort on the edge that closes the TIMEOUT_CYCLES-th stalled cycle
  assign timeout_s      = stalled_s && (stall_cnt_r == 16'(TIMEOUT_CYCLES - 1));
  assign settle_end_s   = (settle_cnt_r == 8'(SETTLE_CYCLES - 1));
  assign in_gain_s      = (state_r == WR_KP) || (state_r == WR_KD) || (state_r == WR_KI);
  assign in_ctrl_s      = state_r inside {WR_SP, WR_PV, SETTLE, RD_RES, DONE};
  // start is taken in IDLE, or during gain writes to chain a control cycle
  assign accept_start_s = start && ((state_r == IDLE) || (in_gain_s && !chain_r));
  assign accept_gain_s  = gain_load && ((state_r == IDLE) || in_ctrl_s);
  assign idle_accept_s  = (state_r == IDLE) && (start || gain_load);

  // Next values of the sampled operands and of the chain/pending flags
  always_comb begin
    sp_nx_s      = sp_r;
    pv_nx_s      = pv_r;
    kp_nx_s      = kp_r;
    kd_nx_s      = kd_r;
    ki_nx_s      = ki_r;
    chain_nx_s   = 1'b0;
    pending_nx_s = 1'b0;
    if (accept_start_s) begin
      sp_nx_s = sp_in;
      pv_nx_s = pv_in;
    end else begin
      sp_nx_s = sp_r;
      pv_nx_s = pv_r;
    end
    if (accept_gain_s) begin
      kp_nx_s = kp_in;
      kd_nx_s = kd_in;
      ki_nx_s = ki_in;
    end else begin
      kp_nx_s = kp_r;
      kd_nx_s = kd_r;
      ki_nx_s = ki_r;
    end
    case (state_r)
      IDLE: begin
        chain_nx_s   = start && gain_load;
        pending_nx_s = 1'b0;
      end
      WR_KP, WR_KD, WR_KI: begin
        chain_nx_s   = (chain_r || start) && !timeout_s;
        pending_nx_s = 1'b0;
      end
      WR_SP, WR_PV, SETTLE, RD_RES: begin
        chain_nx_s   = 1'b0;
        pending_nx_s = (pending_r || gain_load) && !timeout_s;
      end
      default: begin
        chain_nx_s   = 1'b0;
        pending_nx_s = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: advance on access completion, bail out on timeout
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (gain_load)  next_state_s = WR_KP;
        else if (start) next_state_s = WR_SP;
        else            next_state_s = IDLE;
      end
      WR_KP: begin
        if (timeout_s)       next_state_s = IDLE;
        else if (done_acc_s) next_state_s = WR_KD;
        else                 next_state_s = WR_KP;
      end
      WR_KD: begin
        if (timeout_s)       next_state_s = IDLE;
        else if (done_acc_s) next_state_s = WR_KI;
        else                 next_state_s = WR_KD;
      end
      WR_KI: begin
        if (timeout_s)       next_state_s = IDLE;
        else if (done_acc_s) next_state_s = chain_nx_s ? WR_SP : IDLE;
        else                 next_state_s = WR_KI;
      end
      WR_SP: begin
        if (timeout_s)       next_state_s = IDLE;
        else if (done_acc_s) next_state_s = WR_PV;
        else                 next_state_s = WR_SP;
      end
      WR_PV: begin
        if (timeout_s)       next_state_s = IDLE;
        else if (done_acc_s) next_state_s = SETTLE;
        else                 next_state_s = WR_PV;
      end
      SETTLE: begin
        if (settle_end_s) next_state_s = RD_RES;
        else              next_state_s = SETTLE;
      end
      RD_RES: begin
        if (timeout_s)       next_state_s = IDLE;
        else if (done_acc_s) next_state_s = DONE;
        else                 next_state_s = RD_RES;
      end
      DONE: begin
        if (pending_r || gain_load) next_state_s = WR_KP;
        else                        next_state_s = IDLE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Bus request for the state being entered, registered below
  always_comb begin
    addr_nx_s  = 4'd0;
    write_nx_s = 1'b0;
    read_nx_s  = 1'b0;
    wdata_nx_s = 32'd0;
    case (next_state_s)
      WR_KP:  begin addr_nx_s = 4'd1; write_nx_s = 1'b1; wdata_nx_s = kp_nx_s; end
      WR_KD:  begin addr_nx_s = 4'd2; write_nx_s = 1'b1; wdata_nx_s = kd_nx_s; end
      WR_KI:  begin addr_nx_s = 4'd3; write_nx_s = 1'b1; wdata_nx_s = ki_nx_s; end
      WR_SP:  begin addr_nx_s = 4'd4; write_nx_s = 1'b1; wdata_nx_s = sp_nx_s; end
      WR_PV:  begin addr_nx_s = 4'd5; write_nx_s = 1'b1; wdata_nx_s = pv_nx_s; end
      RD_RES: begin addr_nx_s = 4'd0; read_nx_s  = 1'b1; end
      default: begin
        addr_nx_s  = 4'd0;
        write_nx_s = 1'b0;
        read_nx_s  = 1'b0;
        wdata_nx_s = 32'd0;
      end
    endcase
  end

  // Operand, counter, bus and status registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sp_r          <= 32'd0;
      pv_r          <= 32'd0;
      kp_r          <= 32'd0;
      kd_r          <= 32'd0;
      ki_r          <= 32'd0;
      chain_r       <= 1'b0;
      pending_r     <= 1'b0;
      settle_cnt_r  <= 8'd0;
      stall_cnt_r   <= 16'd0;
      avm_address   <= 4'd0;
      avm_write     <= 1'b0;
      avm_read      <= 1'b0;
      avm_writedata <= 32'd0;
      busy          <= 1'b0;
      result_out    <= 32'sd0;
      result_valid  <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      sp_r          <= sp_nx_s;
      pv_r          <= pv_nx_s;
      kp_r          <= kp_nx_s;
      kd_r          <= kd_nx_s;
      ki_r          <= ki_nx_s;
      chain_r       <= chain_nx_s;
      pending_r     <= pending_nx_s;
      settle_cnt_r  <= ((state_r == SETTLE) && !settle_end_s) ? settle_cnt_r + 8'd1 : 8'd0;
      stall_cnt_r   <= (stalled_s && !timeout_s) ? stall_cnt_r + 16'd1 : 16'd0;
      avm_address   <= addr_nx_s;
      avm_write     <= write_nx_s;
      avm_read      <= read_nx_s;
      avm_writedata <= wdata_nx_s;
      busy          <= (next_state_s != IDLE);
      result_valid  <= (state_r == RD_RES) && done_acc_s;
      if ((state_r == RD_RES) && done_acc_s) result_out <= avm_readdata;
      if (timeout_s)          timeout_err <= 1'b1;
      else if (idle_accept_s) timeout_err <= 1'b0;
    end
  end

endmodule
